writeback_arbiter: RTL and testbench
====================================

WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 4, long-latency FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter STARVE_MAX, default 8, consecutive FIFO-waiting cycles before alu_stall asserts.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port alu_valid  input  1  single-cycle result present.
REQ-006 SHALL have port alu_rd  input  5  single-cycle destination register.
REQ-007 SHALL have port alu_data  input  32  single-cycle result value.
REQ-008 SHALL have port alu_stall  output  1  registered; pipeline holds its ALU result while high.
REQ-009 SHALL have port lsu_valid  input  1  long-latency result offered.
REQ-010 SHALL have port lsu_ready  output  1  FIFO can accept; transfer occurs when lsu_valid & lsu_ready.
REQ-011 SHALL have port lsu_rd  input  5  long-latency destination register.
REQ-012 SHALL have port lsu_data  input  32  long-latency result value.
REQ-013 SHALL have port WE3  output  1  register-file write enable, registered.
REQ-014 SHALL have port A3  output  5  register-file write address, registered.
REQ-015 SHALL have port WD3  output  32  register-file write data, registered.
REQ-016 SHALL have port fifo_count  output  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-017 SHALL produce at most one write per cycle; WE3/A3/WD3 update on the clock edge after selection (1-cycle latency).
REQ-018 SHALL select the source with priority: ALU (alu_valid & ~alu_stall), then FIFO head, else idle (WE3=0, A3/WD3 hold).
REQ-019 SHALL drop any write whose rd is 0 from either source: no WE3 pulse, no FIFO entry, no slot consumed.
REQ-020 SHALL drive lsu_ready = (fifo_count < DEPTH), decoded from registered count only.
REQ-021 SHALL allow push and pop in the same cycle, leaving fifo_count unchanged; full blocks push, pop frees space visible the next cycle.
REQ-022 SHALL drain the FIFO in arrival order; pointers wrap modulo DEPTH.
REQ-023 SHALL keep a wait counter: increments each cycle the FIFO is non-empty and the ALU wins; clears on any FIFO pop or when the FIFO is empty.
REQ-024 SHALL set alu_stall on the edge when the wait counter reaches STARVE_MAX-1 and hold it until the cycle after the next FIFO pop.
REQ-025 SHALL ignore alu_valid while alu_stall is high; that cycle pops the FIFO head.
REQ-026 SHALL not write back any entry twice or lose an accepted entry under any valid/ready interleaving.

Reset
REQ-027 SHALL, on rst low (asynchronously), force WE3=0, A3=0, WD3=0, alu_stall=0, fifo_count=0, wait counter=0, both pointers=0.
REQ-028 SHALL discard FIFO contents on reset mid-operation; lsu_ready=1 from the first cycle after rst deasserts.
REQ-029 SHALL make no writes during reset or on the first edge after release unless a source is valid.

Configuration
REQ-030 SHALL support macro WB_BYPASS_EN.
REQ-031 SHALL, with WB_BYPASS_EN defined, route an accepted LSU result directly to the write port (1-cycle latency, no enqueue) when the FIFO is empty and the ALU is not selected.
REQ-032 SHALL, without WB_BYPASS_EN, always enqueue LSU results; minimum LSU-to-WE3 latency is 2 cycles.

Verification
REQ-033 SHALL cover: alu_valid=1, rd=5, data=0xDEADBEEF -> next cycle WE3=1, A3=5, WD3=0xDEADBEEF.
REQ-034 SHALL cover: alu_valid=1 with rd=0 and lsu push with rd=0 -> WE3 stays 0, fifo_count stays 0.
REQ-035 SHALL cover: 4 LSU pushes (rd 1..4) while ALU valid every cycle -> lsu_ready=0 at count 4; alu_stall asserts after 8 waiting cycles; rd 1..4 then written in order.
REQ-036 SHALL cover: DEPTH=4, full FIFO, simultaneous pop and lsu_valid -> no push that cycle; push accepted next cycle; count never exceeds 4.
REQ-037 SHALL cover: 2 entries queued, rst pulsed low mid-cycle -> outputs zero immediately, fifo_count=0, queued entries never written.
REQ-038 SHALL cover: idle, empty FIFO, single LSU push rd=7 -> WE3 one cycle later with WB_BYPASS_EN, two cycles later without.

Source files
------------

// File: rtl/writeback_arbiter.sv
// Register-file writeback arbiter: single-cycle ALU results take priority over a
// long-latency result FIFO, with a starvation guard. Optional feature: WB_BYPASS_EN.
module writeback_arbiter #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alu_valid,
  input  logic [4:0]               alu_rd,
  input  logic [31:0]              alu_data,
  output logic                     alu_stall,
  input  logic                     lsu_valid,
  output logic                     lsu_ready,
  input  logic [4:0]               lsu_rd,
  input  logic [31:0]              lsu_data,
  output logic                     WE3,
  output logic [4:0]               A3,
  output logic [31:0]              WD3,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned WW = $clog2(STARVE_MAX + 1);

  logic [4:0]    rd_mem   [DEPTH];
  logic [31:0]   data_mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [WW-1:0] wait_cnt;

  logic fifo_empty, alu_sel, lsu_acc, push, pop, bypass, waiting, stall_set;

  always_comb begin
    fifo_empty = (fifo_count == '0);
    lsu_ready  = (fifo_count < CW'(DEPTH));
    alu_sel    = alu_valid & ~alu_stall & (alu_rd != '0);
    lsu_acc    = lsu_valid & lsu_ready & (lsu_rd != '0);
    pop        = ~alu_sel & ~fifo_empty;
`ifdef WB_BYPASS_EN
    bypass     = lsu_acc & fifo_empty & ~alu_sel;
`else
    bypass     = 1'b0;
`endif
    push       = lsu_acc & ~bypass;
    waiting    = alu_sel & ~fifo_empty;
    // Stall fires on the STARVE_MAX-th consecutive waiting cycle.
    stall_set  = waiting & (wait_cnt == WW'(STARVE_MAX - 1));
  end

  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[wr_ptr]   <= lsu_rd;
      data_mem[wr_ptr] <= lsu_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      wait_cnt   <= '0;
      alu_stall  <= 1'b0;
      WE3        <= 1'b0;
      A3         <= '0;
      WD3        <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;

      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase

      if (pop || fifo_empty) wait_cnt <= '0;
      else if (waiting)      wait_cnt <= wait_cnt + 1'b1;

      if (pop)            alu_stall <= 1'b0;
      else if (stall_set) alu_stall <= 1'b1;

      if (alu_sel) begin
        WE3 <= 1'b1;
        A3  <= alu_rd;
        WD3 <= alu_data;
      end else if (pop) begin
        WE3 <= 1'b1;
        A3  <= rd_mem[rd_ptr];
        WD3 <= data_mem[rd_ptr];
      end else if (bypass) begin
        WE3 <= 1'b1;
        A3  <= lsu_rd;
        WD3 <= lsu_data;
      end else begin
        WE3 <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed, table-driven bench for writeback_arbiter (DEPTH=4, STARVE_MAX=8).
module tb_writeback_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_data = '0;
  logic        alu_stall;
  logic        lsu_valid = 1'b0;
  logic        lsu_ready;
  logic [4:0]  lsu_rd = '0;
  logic [31:0] lsu_data = '0;
  logic        WE3;
  logic [4:0]  A3;
  logic [31:0] WD3;
  logic [2:0]  fifo_count;

  int n_checks = 0;
  int n_fail   = 0;

  writeback_arbiter #(.DEPTH(4), .STARVE_MAX(8)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_stall(alu_stall),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .WE3(WE3), .A3(A3), .WD3(WD3), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        av;
    logic [4:0]  ard;
    logic [31:0] adat;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ldat;
    logic        we;
    logic [4:0]  a3;
    logic [31:0] wd;
    logic [2:0]  cnt;
    logic        rdy;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] adat,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ldat);
    alu_valid = av; alu_rd = ard; alu_data = adat;
    lsu_valid = lv; lsu_rd = lrd; lsu_data = ldat;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    step();
    step();
    chk("rst_we3", WE3, 0);
    chk("rst_a3", A3, 0);
    chk("rst_wd3", WD3, 0);
    chk("rst_cnt", fifo_count, 0);
    chk("rst_stall", alu_stall, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_ready", lsu_ready, 1);
  endtask

  initial begin
    int exp_idx;
    vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,   1'b1, 5'd5,  32'hDEADBEEF, 3'd0, 1'b1};
    vecs[1] = '{1'b1, 5'd0,  32'h1111,     1'b1, 5'd0,  32'h2222, 1'b0, 5'd5,  32'hDEADBEEF, 3'd0, 1'b1};
    vecs[2] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,   1'b0, 5'd5,  32'hDEADBEEF, 3'd0, 1'b1};
    vecs[3] = '{1'b1, 5'd3,  32'h33,       1'b1, 5'd8,  32'h88,  1'b1, 5'd3,  32'h33,       3'd1, 1'b1};
    vecs[4] = '{1'b1, 5'd4,  32'h44,       1'b1, 5'd9,  32'h99,  1'b1, 5'd4,  32'h44,       3'd2, 1'b1};
    vecs[5] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,   1'b1, 5'd8,  32'h88,       3'd1, 1'b1};
    vecs[6] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd10, 32'hAA,  1'b1, 5'd9,  32'h99,       3'd1, 1'b1};
    vecs[7] = '{1'b1, 5'd0,  32'h55,       1'b0, 5'd0,  32'h0,   1'b1, 5'd10, 32'hAA,       3'd0, 1'b1};
    vecs[8] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,   1'b0, 5'd10, 32'hAA,       3'd0, 1'b1};

    do_reset();

    // Basic priority, rd=0 drop, enqueue/drain.
    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].av, vecs[i].ard, vecs[i].adat, vecs[i].lv, vecs[i].lrd, vecs[i].ldat);
      step();
      chk($sformatf("v%0d_we3", i), WE3, vecs[i].we);
      chk($sformatf("v%0d_a3", i), A3, vecs[i].a3);
      chk($sformatf("v%0d_wd3", i), WD3, vecs[i].wd);
      chk($sformatf("v%0d_cnt", i), fifo_count, vecs[i].cnt);
      chk($sformatf("v%0d_ready", i), lsu_ready, vecs[i].rdy);
    end

    // Starvation: ALU valid every cycle while rd 1..4 are queued.
    do_reset();
    exp_idx = 0;
    for (int c = 0; c < 80 && exp_idx < 4; c++) begin
      drive(1, 5'd20, 32'(c), (c < 4), 5'(c + 1), 32'h100 + 32'(c + 1));
      step();
      if (c == 3) begin
        chk("starve_cnt_full", fifo_count, 4);
        chk("starve_ready_full", lsu_ready, 0);
      end
      if (c == 7) chk("starve_stall_pre", alu_stall, 0);
      if (c == 8) chk("starve_stall_set", alu_stall, 1);
      if (c == 9) begin
        chk("starve_stall_clr", alu_stall, 0);
        chk("starve_first_pop", A3, 1);
      end
      if (WE3 && A3 >= 5'd1 && A3 <= 5'd4) begin
        chk("starve_order_rd", A3, 5'(exp_idx + 1));
        chk("starve_order_wd", WD3, 32'h100 + 32'(exp_idx + 1));
        exp_idx++;
      end
    end
    chk("starve_all_drained", exp_idx, 4);

    // Full FIFO with simultaneous pop and lsu_valid.
    do_reset();
    for (int c = 0; c < 4; c++) begin
      drive(1, 5'd20, 32'h0, 1, 5'(c + 1), 32'h100 + 32'(c + 1));
      step();
    end
    chk("full_cnt", fifo_count, 4);
    drive(0, 0, 0, 1, 5'd9, 32'h109);
    step();
    chk("full_nopush_cnt", fifo_count, 3);
    chk("full_pop_a3", A3, 1);
    step();
    chk("full_push_cnt", fifo_count, 3);
    chk("full_pop2_a3", A3, 2);
    drive(0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 3; c++) begin
      step();
      chk("full_drain_we", WE3, 1);
      chk("full_drain_a3", A3, (c == 2) ? 5'd9 : 5'(c + 3));
      chk("full_cnt_max", (fifo_count <= 3'd4), 1);
    end
    chk("full_drain_wd", WD3, 32'h109);
    chk("full_drain_empty", fifo_count, 0);

    // Reset mid-operation discards queued entries.
    do_reset();
    drive(1, 5'd20, 32'h20, 1, 5'd1, 32'h101);
    step();
    drive(1, 5'd21, 32'h21, 1, 5'd2, 32'h102);
    step();
    chk("mid_cnt_pre", fifo_count, 2);
    drive(0, 0, 0, 0, 0, 0);
    #2 rst = 1'b0;
    #1;
    chk("mid_we3", WE3, 0);
    chk("mid_a3", A3, 0);
    chk("mid_wd3", WD3, 0);
    chk("mid_cnt", fifo_count, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_ready", lsu_ready, 1);
    for (int c = 0; c < 6; c++) begin
      step();
      chk("mid_no_write", WE3, 0);
    end
    chk("mid_cnt_post", fifo_count, 0);

    // Single LSU push into an idle, empty arbiter.
    do_reset();
    drive(0, 0, 0, 1, 5'd7, 32'h777);
    step();
    drive(0, 0, 0, 0, 0, 0);
`ifdef WB_BYPASS_EN
    chk("lat_we_c1", WE3, 1);
    chk("lat_a3_c1", A3, 7);
    chk("lat_cnt_c1", fifo_count, 0);
    step();
    chk("lat_we_c2", WE3, 0);
`else
    chk("lat_we_c1", WE3, 0);
    chk("lat_cnt_c1", fifo_count, 1);
    step();
    chk("lat_we_c2", WE3, 1);
    chk("lat_a3_c2", A3, 7);
`endif
    chk("lat_wd", WD3, 32'h777);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
